// File: rtl/wave_capture_multi_pkg.sv
// Shared types for the triggered waveform capture block: capture FSM state
// codes and trigger-mode encodings.
package wave_capture_multi_pkg;

    typedef enum logic [2:0] {
        ST_ARMED  = 3'b001,
        ST_ACTIVE = 3'b010,
        ST_WAIT   = 3'b100
    } cap_state_e;

    // Code 2'b11 is decoded as rising by the trigger logic's default branch.
    localparam logic [1:0] TRIG_RISING  = 2'b00;
    localparam logic [1:0] TRIG_FALLING = 2'b01;
    localparam logic [1:0] TRIG_FREE    = 2'b10;

endpackage

// File: rtl/wave_capture_multi_trigger_detect.sv
// Level-crossing trigger: remembers the previous accepted sample and flags a
// rising/falling crossing of trig_level_i (or every sample when free-running).
module wave_capture_multi_trigger_detect
    import wave_capture_multi_pkg::*;
#(
    parameter int SAMPLE_W = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sample_valid_i,
    input  logic signed [SAMPLE_W-1:0] sample_i,
    input  logic        [1:0]          trig_mode_i,
    input  logic signed [SAMPLE_W-1:0] trig_level_i,
    output logic                       trig_o
);

    logic signed [SAMPLE_W-1:0] prev_q;
    logic signed [SAMPLE_W-1:0] prev_d;
    logic                       prev_valid_q;
    logic                       prev_valid_d;
    logic                       cur_at_or_above;
    logic                       prev_below;

    always_comb begin
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        if (sample_valid_i) begin
            prev_d       = sample_i;
            prev_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
        end else begin
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
        end
    end

    assign cur_at_or_above = (sample_i >= trig_level_i);
    assign prev_below      = (prev_q < trig_level_i);

    always_comb begin
        trig_o = 1'b0;
        case (trig_mode_i)
            TRIG_FREE:    trig_o = sample_valid_i;
            TRIG_FALLING: trig_o = sample_valid_i && prev_valid_q && !prev_below && !cur_at_or_above;
            default:      trig_o = sample_valid_i && prev_valid_q && prev_below && cur_at_or_above;
        endcase
    end

endmodule

// File: rtl/wave_capture_multi.sv
// Triggered, decimating waveform capture into one half of a ping-pong display
// RAM; the filled half is handed to the display when it reports idle.
module wave_capture_multi
    import wave_capture_multi_pkg::*;
#(
    parameter int SAMPLE_W   = 16,
    parameter int OUT_W      = 8,
    parameter int DEPTH_LOG2 = 8,
    parameter int DECIM_W    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  new_sample_ready,
    input  logic [SAMPLE_W-1:0]   new_sample_in,
    input  logic                  wave_display_idle,
    input  logic [1:0]            trig_mode,
    input  logic [SAMPLE_W-1:0]   trig_level,
    input  logic [DECIM_W-1:0]    decim,
    output logic [DEPTH_LOG2:0]   write_address,
    output logic                  write_enable,
    output logic [OUT_W-1:0]      write_sample,
    output logic                  read_index,
    output logic                  capture_done
);

    cap_state_e             state_q, state_d;
    logic [DEPTH_LOG2-1:0]  count_q, count_d;
    logic [DECIM_W-1:0]     decim_cnt_q, decim_cnt_d;
    logic [DECIM_W-1:0]     decim_lat_q, decim_lat_d;
    logic                   read_index_q, read_index_d;
    logic                   done_q, done_d;
    logic                   we_q, we_d;
    logic [DEPTH_LOG2:0]    addr_q, addr_d;
    logic [OUT_W-1:0]       sample_q, sample_d;

    logic                   trig;
    logic                   do_write;
    logic [DEPTH_LOG2-1:0]  wr_count;
    logic [OUT_W-1:0]       sample_ob;

    // Trigger inputs are only consulted in ARMED, so mid-capture changes to
    // trig_mode/trig_level have no effect on the capture in progress.
    wave_capture_multi_trigger_detect #(
        .SAMPLE_W (SAMPLE_W)
    ) u_trig (
        .clk            (clk),
        .reset          (reset),
        .sample_valid_i (new_sample_ready),
        .sample_i       (new_sample_in),
        .trig_mode_i    (trig_mode),
        .trig_level_i   (trig_level),
        .trig_o         (trig)
    );

    // Offset-binary: flip the sign bit and keep the top OUT_W bits.
    assign sample_ob = {~new_sample_in[SAMPLE_W-1], new_sample_in[SAMPLE_W-2 -: OUT_W-1]};

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        decim_cnt_d  = decim_cnt_q;
        decim_lat_d  = decim_lat_q;
        read_index_d = read_index_q;
        done_d       = 1'b0;
        do_write     = 1'b0;
        wr_count     = count_q;

        case (state_q)
            ST_ARMED: begin
                if (trig) begin
                    do_write    = 1'b1;
                    wr_count    = '0;
                    count_d     = DEPTH_LOG2'(1);
                    decim_cnt_d = '0;
                    decim_lat_d = decim;
                    state_d     = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (new_sample_ready) begin
                    if (decim_cnt_q == decim_lat_q) begin
                        do_write    = 1'b1;
                        count_d     = count_q + DEPTH_LOG2'(1);
                        decim_cnt_d = '0;
                        if (count_q == '1) begin
                            state_d = ST_WAIT;
                        end
                    end else begin
                        decim_cnt_d = decim_cnt_q + DECIM_W'(1);
                    end
                end
            end
            ST_WAIT: begin
                if (wave_display_idle) begin
                    read_index_d = ~read_index_q;
                    done_d       = 1'b1;
                    state_d      = ST_ARMED;
                end
            end
            default: begin
                state_d = ST_ARMED;
            end
        endcase

        we_d     = do_write;
        addr_d   = do_write ? {~read_index_q, wr_count} : addr_q;
        sample_d = do_write ? sample_ob : sample_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_ARMED;
            count_q      <= '0;
            decim_cnt_q  <= '0;
            decim_lat_q  <= '0;
            read_index_q <= 1'b0;
            done_q       <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            sample_q     <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            decim_cnt_q  <= decim_cnt_d;
            decim_lat_q  <= decim_lat_d;
            read_index_q <= read_index_d;
            done_q       <= done_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            sample_q     <= sample_d;
        end
    end

    assign write_address = addr_q;
    assign write_enable  = we_q;
    assign write_sample  = sample_q;
    assign read_index    = read_index_q;
    assign capture_done  = done_q;

endmodule
